// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state, decision encoding, counter sizing.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DEC_NONE = 2'd0,
        DEC_GT   = 2'd1,
        DEC_LT   = 2'd2
    } decision_t;

    // Beat counter must be able to hold the value WIDTH itself, since it
    // holds at WIDTH after the word completes.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_mag_comparator.sv
// Word-level magnitude compare built from an MSB-first stream of per-bit eq/gt/lt beats.
// Latency: result and one-cycle done pulse appear one cycle after the WIDTH-th beat is sampled.
// Backpressure: none; bit_valid gaps of any length simply hold state, start aborts and restarts.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   start                    begin a new word (also aborts one in progress)
//   bit_valid                bit_eq/bit_gt/bit_lt carry a beat this cycle
//   bit_eq, bit_gt, bit_lt   per-bit compare result from the upstream cell
//   busy                     high while scanning a word
//   done                     one-cycle pulse when eq/gt/lt/err become valid
//   eq, gt, lt, err          word result, held until the next start
//   beat_cnt                 beats consumed in the current word
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_eq,
    input  logic             bit_gt,
    input  logic             bit_lt,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             err,
    output logic [CNT_W-1:0] beat_cnt
);

    state_t    state;
    state_t    state_nxt;
    logic      decided;
    decision_t decision;
    logic      err_flag;

    logic      beat_take;
    logic      last_beat;
    logic      onehot;
    logic      err_nxt;
    logic      decided_nxt;
    decision_t decision_nxt;

    // A start in SCAN wins over a same-cycle beat, so the beat is dropped.
    assign beat_take = (state == SCAN) && bit_valid && !start;
    assign last_beat = beat_take && (beat_cnt == CNT_W'(WIDTH - 1));

    // Exactly one of the three bits set: odd parity excludes 0 and 2 set,
    // the AND term excludes all three set.
    assign onehot  = (bit_eq ^ bit_gt ^ bit_lt) && !(bit_eq && bit_gt && bit_lt);
    assign err_nxt = err_flag || !onehot;

    // The first gt/lt beat from the MSB end decides the word; later beats
    // are counted but cannot override it.
    always_comb begin
        decided_nxt  = decided;
        decision_nxt = decision;
        if (!decided) begin
            if (bit_gt) begin
                decided_nxt  = 1'b1;
                decision_nxt = DEC_GT;
            end else if (bit_lt) begin
                decided_nxt  = 1'b1;
                decision_nxt = DEC_LT;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (start) begin
                    state_nxt = SCAN;
                end else if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == SCAN);
    end

    // Counter, decision tracking and held word result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            err      <= 1'b0;
            beat_cnt <= '0;
            decided  <= 1'b0;
            decision <= DEC_NONE;
            err_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                eq       <= 1'b0;
                gt       <= 1'b0;
                lt       <= 1'b0;
                err      <= 1'b0;
                beat_cnt <= '0;
                decided  <= 1'b0;
                decision <= DEC_NONE;
                err_flag <= 1'b0;
            end else if (beat_take) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                err_flag <= err_nxt;
                decided  <= decided_nxt;
                decision <= decision_nxt;
                if (last_beat) begin
                    done <= 1'b1;
                    // Results are taken from the _nxt values so the final
                    // beat itself participates in the decision and error.
                    if (err_nxt) begin
                        eq  <= 1'b0;
                        gt  <= 1'b0;
                        lt  <= 1'b0;
                        err <= 1'b1;
                    end else begin
                        eq  <= !decided_nxt;
                        gt  <= (decision_nxt == DEC_GT);
                        lt  <= (decision_nxt == DEC_LT);
                        err <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             bit_valid;
    logic             bit_eq;
    logic             bit_gt;
    logic             bit_lt;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             err;
    logic [CNT_W-1:0] beat_cnt;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
        logic err;
    } res_t;

    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_eq    (bit_eq),
        .bit_gt    (bit_gt),
        .bit_lt    (bit_lt),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .err       (err),
        .beat_cnt  (beat_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every done pulse pops and compares one expected word result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            res_t got;
            res_t want;
            got = '{eq: eq, gt: gt, lt: lt, err: err};
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                want = exp_q.pop_front();
                check("word_result", 32'(got), 32'(want));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_eq    = 1'b0;
        bit_gt    = 1'b0;
        bit_lt    = 1'b0;
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input bit bad);
        res_t r;
        if (bad) r = '{eq: 1'b0, gt: 1'b0, lt: 1'b0, err: 1'b1};
        else     r = '{eq: (a == b), gt: (a > b), lt: (a < b), err: 1'b0};
        return r;
    endfunction

    task automatic do_start();
        start     = 1'b1;
        bit_valid = 1'b1;   // must be ignored in IDLE alongside start
        bit_gt    = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic drive_beat(input logic a_bit, input logic b_bit, input bit bad);
        bit_valid = 1'b1;
        bit_eq    = (a_bit == b_bit);
        bit_gt    = a_bit & ~b_bit;
        bit_lt    = ~a_bit & b_bit;
        if (bad) begin
            bit_eq = 1'b1;
            bit_gt = 1'b1;
        end
        tick();
        idle_inputs();
    endtask

    // Streams a full word MSB first into an already-started comparison.
    // gap_at: beat index before which gap_len idle cycles are inserted (-1: none).
    // bad_at: beat index driven as a non-one-hot beat (-1: none).
    task automatic stream(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int gap_at, input int gap_len, input int bad_at, input res_t r);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    check({name, "_gap_busy"}, 32'(busy), 32'd1);
                    check({name, "_gap_no_done"}, 32'(done), 32'd0);
                    check({name, "_gap_cnt"}, 32'(beat_cnt), 32'(i));
                end
            end
            drive_beat(a[WIDTH-1-i], b[WIDTH-1-i], i == bad_at);
            if (i < WIDTH - 1) check({name, "_early_done"}, 32'(done), 32'd0);
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_cnt_end"}, 32'(beat_cnt), 32'(WIDTH));
        tick();
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_held"}, 32'({eq, gt, lt, err}), 32'(r));
        check({name, "_cnt_held"}, 32'(beat_cnt), 32'(WIDTH));
    endtask

    task automatic send_word(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int gap_at, input int gap_len, input int bad_at);
        res_t r;
        r = model(a, b, bad_at >= 0);
        exp_q.push_back(r);
        do_start();
        check({name, "_start_busy"}, 32'(busy), 32'd1);
        check({name, "_start_cnt"}, 32'(beat_cnt), 32'd0);
        check({name, "_start_clear"}, 32'({eq, gt, lt, err}), 32'd0);
        stream(name, a, b, gap_at, gap_len, bad_at, r);
    endtask

    initial begin
        res_t r;
        idle_inputs();
        rst = 1'b1;
        #1;
        check("reset_outputs", 32'({busy, done, eq, gt, lt, err}), 32'd0);
        check("reset_cnt", 32'(beat_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // bit_valid in IDLE without start does nothing
        drive_beat(1'b1, 1'b0, 1'b0);
        check("idle_ignore", 32'({busy, beat_cnt}), 32'd0);

        send_word("eq_a5", 8'hA5, 8'hA5, -1, 0, -1);
        send_word("gt_80", 8'h80, 8'h7F, -1, 0, -1);
        send_word("lt_gap", 8'h3C, 8'h3D, 4, 3, -1);

        // Restart mid-word: 5 beats, then start together with a valid beat.
        do_start();
        for (int i = 0; i < 5; i++) drive_beat(1'b0, 1'b1, 1'b0);
        check("restart_cnt5", 32'(beat_cnt), 32'd5);
        r = model(8'h01, 8'h00, 1'b0);
        exp_q.push_back(r);
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_lt    = 1'b1;
        tick();
        idle_inputs();
        check("restart_no_done", 32'(done), 32'd0);
        check("restart_cnt0", 32'(beat_cnt), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        stream("restart_gt", 8'h01, 8'h00, -1, 0, -1, r);

        send_word("err_beat3", 8'hA5, 8'hA5, -1, 0, 2);
        send_word("clean_after_err", 8'h12, 8'h34, -1, 0, -1);

        // Asynchronous reset mid-SCAN while beat 4 is on the bus.
        do_start();
        for (int i = 0; i < 3; i++) drive_beat(1'b1, 1'b0, 1'b0);
        bit_valid = 1'b1;
        bit_gt    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_outputs", 32'({busy, done, eq, gt, lt, err}), 32'd0);
        check("arst_cnt", 32'(beat_cnt), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            bit_valid = 1'b1;
            bit_eq    = 1'b1;
            tick();
        end
        idle_inputs();
        check("post_rst_idle", 32'({busy, done, beat_cnt}), 32'd0);

        send_word("after_rst", 8'hFF, 8'h00, -1, 0, -1);
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        check("timeout", 32'd1, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
